// File: rtl/datapath_sequencer.sv
// Sequencer that stages two operands through data memory and the register file,
// runs the adder/subtractor on them and writes the result back to a destination register.
module datapath_sequencer #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned A_SLOT   = 0,
  parameter int unsigned B_SLOT   = 1,
  parameter int unsigned RA       = 0,
  parameter int unsigned RB       = 1,
  parameter int unsigned RD       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORDSIZE-1:0] num1,
  input  logic [WORDSIZE-1:0] num2,
  input  logic                operation_in,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [WORDSIZE-1:0] dm_data_input,
  output logic                dm_write_enable,
  output logic                dm_read,
  input  logic [WORDSIZE-1:0] dm_data_output,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [WORDSIZE-1:0] rf_write_data,
  output logic [ADDR_W-1:0]   rf_addr_a,
  output logic [ADDR_W-1:0]   rf_addr_b,
  input  logic [WORDSIZE-1:0] rf_data_a,
  input  logic [WORDSIZE-1:0] rf_data_b,
  output logic [WORDSIZE-1:0] factor_a,
  output logic [WORDSIZE-1:0] factor_b,
  output logic                operation,
  input  logic [WORDSIZE-1:0] adder_result
);

  typedef enum logic [3:0] {
    IDLE, WR_A, RD_A, LD_A, WR_B, RD_B, LD_B, EXEC, WB, DONE
  } state_t;

  state_t              state, state_next;
  logic [WORDSIZE-1:0] cap_a, cap_b;
  logic                cap_op;
  logic                accept;

  // A new request is only taken while no run is in flight.
  assign accept    = start && (state == IDLE || state == DONE);
  assign operation = cap_op;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cap_a  <= '0;
      cap_b  <= '0;
      cap_op <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_a  <= num1;
        cap_b  <= num2;
        cap_op <= operation_in;
      end
      if (state == EXEC) result <= adder_result;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    busy            = (state != IDLE);
    done            = 1'b0;
    dm_addr         = '0;
    dm_data_input   = '0;
    dm_write_enable = 1'b0;
    dm_read         = 1'b0;
    rf_write_en     = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    rf_addr_a       = '0;
    rf_addr_b       = '0;
    factor_a        = '0;
    factor_b        = '0;

    case (state)
      IDLE: if (start) state_next = WR_A;
      WR_A: begin
        dm_addr         = ADDR_W'(A_SLOT);
        dm_data_input   = cap_a;
        dm_write_enable = 1'b1;
        state_next      = RD_A;
      end
      RD_A: begin
        dm_addr    = ADDR_W'(A_SLOT);
        dm_read    = 1'b1;
        state_next = LD_A;
      end
      LD_A: begin
        rf_write_en   = 1'b1;
        rf_write_addr = ADDR_W'(RA);
        rf_write_data = dm_data_output;
        state_next    = WR_B;
      end
      WR_B: begin
        dm_addr         = ADDR_W'(B_SLOT);
        dm_data_input   = cap_b;
        dm_write_enable = 1'b1;
        state_next      = RD_B;
      end
      RD_B: begin
        dm_addr    = ADDR_W'(B_SLOT);
        dm_read    = 1'b1;
        state_next = LD_B;
      end
      LD_B: begin
        rf_write_en   = 1'b1;
        rf_write_addr = ADDR_W'(RB);
        rf_write_data = dm_data_output;
        state_next    = EXEC;
      end
      EXEC: begin
        rf_addr_a  = ADDR_W'(RA);
        rf_addr_b  = ADDR_W'(RB);
        factor_a   = rf_data_a;
        factor_b   = rf_data_b;
        state_next = WB;
      end
      WB: begin
        rf_write_en   = 1'b1;
        rf_write_addr = ADDR_W'(RD);
        rf_write_data = result;
        state_next    = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? WR_A : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench: behavioural data memory, register file and adder around the
// sequencer, with immediate-assertion checks against hand-computed values.
module tb_datapath_sequencer;

  localparam int W = 64;
  localparam int A = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  num1 = '0, num2 = '0;
  logic          operation_in = 1'b0;
  logic          busy, done;
  logic [W-1:0]  result;
  logic [A-1:0]  dm_addr;
  logic [W-1:0]  dm_data_input;
  logic          dm_write_enable, dm_read;
  logic [W-1:0]  dm_data_output;
  logic          rf_write_en;
  logic [A-1:0]  rf_write_addr, rf_addr_a, rf_addr_b;
  logic [W-1:0]  rf_write_data, rf_data_a, rf_data_b;
  logic [W-1:0]  factor_a, factor_b, adder_result;
  logic          operation;

  datapath_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
    .operation_in(operation_in), .busy(busy), .done(done), .result(result),
    .dm_addr(dm_addr), .dm_data_input(dm_data_input),
    .dm_write_enable(dm_write_enable), .dm_read(dm_read),
    .dm_data_output(dm_data_output), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .factor_a(factor_a), .factor_b(factor_b), .operation(operation),
    .adder_result(adder_result)
  );

  always #5 clk = ~clk;

  // Datapath models: registered memory read, combinational register-file read.
  logic [W-1:0] mem [32];
  logic [W-1:0] rf  [32];
  always @(posedge clk) begin
    if (dm_write_enable) mem[dm_addr] <= dm_data_input;
    if (dm_read)         dm_data_output <= mem[dm_addr];
    if (rf_write_en)     rf[rf_write_addr] <= rf_write_data;
  end
  assign rf_data_a    = rf[rf_addr_a];
  assign rf_data_b    = rf[rf_addr_b];
  assign adder_result = operation ? factor_a - factor_b : factor_a + factor_b;

  int n_dm_wr = 0, n_dm_rd = 0, n_rf_wr = 0;
  always @(negedge clk) begin
    if (dm_write_enable) n_dm_wr <= n_dm_wr + 1;
    if (dm_read)         n_dm_rd <= n_dm_rd + 1;
    if (rf_write_en)     n_rf_wr <= n_rf_wr + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Launch at the current negedge; returns at the negedge of cycle 9 (DONE).
  // poke_k > 0 raises start with num1=99 during that cycle to test ignoring.
  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic op, input int poke_k, input logic [W-1:0] exp);
    logic [9:1]   hist;
    logic [W-1:0] res_wb;
    num1 = a; num2 = b; operation_in = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hist = '0;
    res_wb = '0;
    for (int k = 1; k <= 9; k++) begin
      hist[k] = done;
      if (k == 8) res_wb = result;
      if (k < 9) begin
        if (k == poke_k) begin num1 = 64'd99; start = 1'b1; end
        @(negedge clk);
        start = 1'b0;
      end
    end
    check({tag, " done_timing"}, W'(hist), W'(9'h100));
    check({tag, " result_in_wb"}, res_wb, exp);
    check({tag, " result_in_done"}, result, exp);
    check({tag, " rf_rd"}, rf[2], exp);
  endtask

  int s_wr, s_rd, s_rf;

  initial begin
    #12;
    check("reset_ctrl", W'({busy, done, dm_write_enable, dm_read, rf_write_en}), '0);
    check("reset_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1 add, with per-run strobe counting (T6)
    s_wr = n_dm_wr; s_rd = n_dm_rd; s_rf = n_rf_wr;
    run("t1_add", 64'd25, 64'd17, 1'b0, 0, 64'd42);
    check("t1_dm0", mem[0], 64'd25);
    check("t1_dm1", mem[1], 64'd17);
    @(negedge clk);
    check("t6_dm_writes", W'(n_dm_wr - s_wr), 64'd2);
    check("t6_dm_reads", W'(n_dm_rd - s_rd), 64'd2);
    check("t6_rf_writes", W'(n_rf_wr - s_rf), 64'd3);

    // T2 subtract producing a negative value
    run("t2_sub", 64'd10, 64'd30, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFEC);
    @(negedge clk);

    // T3 wraparound, then busy must drop
    run("t3_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 64'd0);
    @(negedge clk);
    check("t3_busy_low", W'(busy), 64'd0);
    check("t3_done_low", W'(done), 64'd0);

    // T4 start in EXEC ignored; start in DONE accepted back-to-back
    run("t4_ignore", 64'd50, 64'd8, 1'b0, 7, 64'd58);
    run("t4_b2b", 64'd3, 64'd4, 1'b0, 0, 64'd7);
    @(negedge clk);
    check("t4_idle", W'(busy), 64'd0);

    // T5 reset during RD_B
    num1 = 64'd100; num2 = 64'd200; operation_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_in_rd_b", W'({dm_read, dm_addr}), W'({1'b1, 5'd1}));
    rst = 1'b1;
    #1;
    check("t5_ctrl_zero", W'({busy, done, dm_write_enable, dm_read, rf_write_en}), '0);
    check("t5_addr_zero", W'({dm_addr, rf_write_addr, rf_addr_a, rf_addr_b}), '0);
    check("t5_result_zero", result, '0);
    check("t5_operation_zero", W'(operation), '0);
    s_wr = n_dm_wr; s_rf = n_rf_wr;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_dm_write", W'(n_dm_wr - s_wr), '0);
    check("t5_no_rf_write", W'(n_rf_wr - s_rf), '0);
    check("t5_rf_b_untouched", rf[1], 64'd4);
    run("t5_after", 64'd5, 64'd6, 1'b0, 0, 64'd11);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
